irq_pending_ctrl: RTL
=====================

# irq_pending_ctrl

Sequential front end for the 8-line priority-encoding path. Captures rising edges on eight interrupt request lines into a pending register, applies a mask, and selects the highest-numbered unmasked pending line; bit 7 has the highest priority. Presents the selected 3-bit index through a request/acknowledge handshake, then tracks in-service status until an end-of-interrupt pulse. Sits between raw request sources and the consumer that services the 3-bit code.

## Interface
Parameters:
- none; width is fixed at 8 lines and 3-bit index.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  controller enable; gates request issue only.
- irq_in  input  8  request lines; already synchronous to clk.
- mask  input  8  1 = line blocked from selection; it is still latched into pending.
- irq_ack  input  1  consumer accepts the presented index (single-cycle pulse).
- eoi  input  1  end of interrupt for the in-service line (single-cycle pulse).
- irq_req  output  1  index valid; request to consumer.
- irq_id  output  3  index of the selected line; stable while irq_req=1.
- in_service  output  1  an acknowledged interrupt is being serviced.
- pending  output  8  pending register, visible for status.

## Operation
- Reset value of all state is 0: pending=0, prev_in=0, irq_req=0, irq_id=3'b000, in_service=0, state=IDLE.
- Edge capture:
  - prev_in <= irq_in every cycle.
  - pending[i] is set when irq_in[i] & ~prev_in[i].
  - A level held high sets the bit once only.
- Candidate set is cand = pending & ~mask. sel = index of the highest set bit of cand.
- FSM states: IDLE, REQ, SVC.
  - IDLE -> REQ when en=1 and cand!=0. On that edge, register irq_id<=sel and set irq_req<=1.
  - REQ:
    - irq_id is frozen, even if a higher-priority line arrives.
    - On irq_ack=1: clear pending[irq_id], set irq_req<=0 and in_service<=1, go to SVC.
    - If en=0 (and no ack): drop the request. irq_req<=0, go to IDLE; the pending bit is retained.
    - When irq_ack and en=0 occur together, ack wins.
  - SVC:
    - Wait for eoi=1, then in_service<=0 and go to IDLE.
    - en has no effect while in SVC.
- Ignored inputs:
  - irq_ack outside REQ.
  - eoi outside SVC.
  - An eoi coincident with the ack, while in REQ.
- Same-cycle set and clear on the same bit (new edge on line irq_id during its ack): set wins, so the new event is retained.
- Mask changes take effect on the next IDLE evaluation. They do not affect an index already presented.

## Timing
- Edge-to-request latency is 2 cycles. irq_in[i] rises before edge k; pending[i]=1 after edge k; irq_req=1 with irq_id valid after edge k+1.
- Ack to in_service is 1 cycle. irq_ack is sampled at edge m; after edge m, irq_req=0, in_service=1, and pending[id]=0.
- eoi to next request: eoi at edge p gives IDLE after p. If cand!=0, irq_req rises after edge p+1. The minimum request spacing is therefore 1 idle cycle.
- Reset asserted mid-operation immediately forces all outputs to their reset values, regardless of state or clk.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Shared package holds:
  - the FSM state encoding constants (IDLE=2'd0, REQ=2'd1, SVC=2'd2);
  - IRQ_N=8 and IRQ_IDW=3.
- One natural sub-module: irq_edge_latch. It holds prev_in and pending, with inputs for a set vector and a clear-enable plus clear index, and applies set-wins priority.
- Top level contains the highest-bit select function, the FSM, and the output registers.

## Test plan
- Reset: assert rst mid-SVC, with pending=8'hA0 -> all outputs 0 immediately; state IDLE after release.
- Single line: en=1, mask=0, pulse irq_in[3] -> irq_req=1, irq_id=3 after 2 cycles; ack -> pending=8'h00, in_service=1; eoi -> in_service=0.
- Priority and freeze:
  - Raise irq_in[2] and irq_in[5] together -> irq_id=5.
  - Raise irq_in[7] while in REQ -> irq_id stays 5.
  - Ack and eoi -> next request has irq_id=7, then irq_id=2.
- Mask: mask=8'h80, edges on bits 7 and 1 -> irq_id=1, pending=8'h82. Clear mask after service -> irq_id=7.
- Level vs edge: hold irq_in[4]=1 for 20 cycles, ack and eoi once -> no second request. Toggle low then high -> new request with irq_id=4.
- Boundary conditions:
  - en=0 in REQ -> irq_req drops next cycle and pending is retained.
  - Ack coincident with a new irq_in[id] edge -> pending[id] stays 1.
  - Stray eoi in IDLE -> no effect.

Source files
------------

// File: rtl/irq_pending_ctrl_pkg.sv
// rtl/irq_pending_ctrl_pkg.sv - shared constants and FSM encoding for irq_pending_ctrl
package irq_pending_ctrl_pkg;

    localparam int IRQ_N   = 8;
    localparam int IRQ_IDW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

endpackage

// File: rtl/irq_pending_ctrl_edge_latch.sv
// rtl/irq_pending_ctrl_edge_latch.sv - rising-edge capture into pending with set-wins clear
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   lines     - set vector source: request lines, a bit is set on its rising edge
//   clr_en    - clear one pending bit this cycle
//   clr_idx   - index of the bit to clear
//   pending   - pending register
module irq_edge_latch
    import irq_pending_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [IRQ_N-1:0]   lines,
    input  logic               clr_en,
    input  logic [IRQ_IDW-1:0] clr_idx,
    output logic [IRQ_N-1:0]   pending
);

    logic [IRQ_N-1:0] prev_in;
    logic [IRQ_N-1:0] rise;
    logic [IRQ_N-1:0] clr_vec;

    assign rise    = lines & ~prev_in;
    assign clr_vec = clr_en ? (IRQ_N'(1) << clr_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_in <= '0;
            pending <= '0;
        end else begin
            prev_in <= lines;
            // Set is applied after clear so a new edge during its own ack survives.
            pending <= (pending & ~clr_vec) | rise;
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// rtl/irq_pending_ctrl.sv - pending/mask/priority select with req-ack and in-service tracking
//
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   en          - enables issuing new requests
//   irq_in      - request lines (synchronous to clk)
//   mask        - 1 blocks a line from selection (still latched into pending)
//   irq_ack     - consumer accepts presented index (pulse)
//   eoi         - end of interrupt for the in-service line (pulse)
//   irq_req     - index valid
//   irq_id      - selected line index, stable while irq_req=1
//   in_service  - an acknowledged interrupt is being serviced
//   pending     - pending register status
module irq_pending_ctrl
    import irq_pending_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [IRQ_N-1:0]   irq_in,
    input  logic [IRQ_N-1:0]   mask,
    input  logic               irq_ack,
    input  logic               eoi,
    output logic               irq_req,
    output logic [IRQ_IDW-1:0] irq_id,
    output logic               in_service,
    output logic [IRQ_N-1:0]   pending
);

    // Highest set bit wins; later loop iterations override earlier ones.
    function automatic logic [IRQ_IDW-1:0] hi_sel(input logic [IRQ_N-1:0] v);
        logic [IRQ_IDW-1:0] s;
        s = '0;
        for (int i = 0; i < IRQ_N; i++) begin
            if (v[i]) s = IRQ_IDW'(i);
        end
        return s;
    endfunction

    state_t             state, state_n;
    logic               req_n;
    logic [IRQ_IDW-1:0] id_n;
    logic               svc_n;
    logic               clr_en;
    logic [IRQ_N-1:0]   cand;

    assign cand = pending & ~mask;

    irq_edge_latch u_latch (
        .clk     (clk),
        .rst     (rst),
        .lines   (irq_in),
        .clr_en  (clr_en),
        .clr_idx (irq_id),
        .pending (pending)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            irq_req    <= 1'b0;
            irq_id     <= '0;
            in_service <= 1'b0;
        end else begin
            state      <= state_n;
            irq_req    <= req_n;
            irq_id     <= id_n;
            in_service <= svc_n;
        end
    end

    always_comb begin
        state_n = state;
        req_n   = irq_req;
        id_n    = irq_id;
        svc_n   = in_service;
        clr_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && (cand != '0)) begin
                    state_n = REQ;
                    req_n   = 1'b1;
                    id_n    = hi_sel(cand);
                end
            end
            REQ: begin
                // Ack takes precedence over a simultaneous enable drop.
                if (irq_ack) begin
                    clr_en  = 1'b1;
                    req_n   = 1'b0;
                    svc_n   = 1'b1;
                    state_n = SVC;
                end else if (!en) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            SVC: begin
                if (eoi) begin
                    svc_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
                svc_n   = 1'b0;
            end
        endcase
    end

endmodule
